// File: rtl/stopwatch_counter_pkg.sv
// Shared stopwatch definitions: digit width, BCD limits, field-select codes,
// and the two-digit BCD field type with its increment helpers.
package stopwatch_counter_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd_field_t;

    // Which update the digit logic applies on the current cycle.
    typedef enum logic [1:0] {
        PATH_HOLD    = 2'd0,
        PATH_COUNT   = 2'd1,
        PATH_ADJ_MIN = 2'd2,
        PATH_ADJ_SEC = 2'd3
    } path_e;

    function automatic logic field_at_max(bcd_field_t f, logic [DIGIT_W-1:0] tens_max);
        return (f.tens >= tens_max) && (f.ones >= BCD_MAX);
    endfunction

    // Comparisons use >= so a corrupted digit still lands back in BCD range.
    function automatic bcd_field_t field_inc(bcd_field_t f, logic [DIGIT_W-1:0] tens_max);
        bcd_field_t n;
        if (field_at_max(f, tens_max)) begin
            n.tens = '0;
            n.ones = '0;
        end else if (f.ones >= BCD_MAX) begin
            n.tens = f.tens + 1'b1;
            n.ones = '0;
        end else begin
            n.tens = f.tens;
            n.ones = f.ones + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_counter_rise_detect.sv
// Rising-edge detector for a level input sampled in the clk_in domain.
// The history register tracks the level during reset, so a level already high at release is not an edge.
module rise_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_d;

    always_ff @(posedge clk_in) begin
        level_d <= level;
    end

    assign rise = level & ~level_d & ~rst;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch: counts once per tick_in rise while running, supports
// pause/resume and per-field adjust on adj_tick rises. All outputs registered.
module stopwatch_counter #(
    parameter int MIN_TENS_MAX = 5,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       adj_tick,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       rollover
);
    import stopwatch_counter_pkg::*;

    localparam logic [DIGIT_W-1:0] MIN_TM = DIGIT_W'(MIN_TENS_MAX);
    localparam logic [DIGIT_W-1:0] SEC_TM = DIGIT_W'(SEC_TENS_MAX);

    logic       tick_rise;
    logic       adj_rise;
    path_e      path;
    bcd_field_t min_q, min_d;
    bcd_field_t sec_q, sec_d;
    logic       running_q;
    logic       rollover_q, rollover_d;

    rise_detect u_tick_rise (
        .clk_in (clk_in),
        .rst    (rst),
        .level  (tick_in),
        .rise   (tick_rise)
    );

    rise_detect u_adj_rise (
        .clk_in (clk_in),
        .rst    (rst),
        .level  (adj_tick),
        .rise   (adj_rise)
    );

    // adj sampled this cycle picks the path; counting uses pre-toggle running.
    always_comb begin
        path = PATH_HOLD;
        if (adj) begin
            if (adj_rise) begin
                path = (sel == SEL_SEC) ? PATH_ADJ_SEC : PATH_ADJ_MIN;
            end
        end else if (running_q && tick_rise) begin
            path = PATH_COUNT;
        end
    end

    always_comb begin
        min_d      = min_q;
        sec_d      = sec_q;
        rollover_d = 1'b0;
        case (path)
            PATH_COUNT: begin
                sec_d = field_inc(sec_q, SEC_TM);
                if (field_at_max(sec_q, SEC_TM)) begin
                    min_d      = field_inc(min_q, MIN_TM);
                    rollover_d = field_at_max(min_q, MIN_TM);
                end
            end
            PATH_ADJ_MIN: min_d = field_inc(min_q, MIN_TM);
            PATH_ADJ_SEC: sec_d = field_inc(sec_q, SEC_TM);
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            min_q      <= '0;
            sec_q      <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            min_q      <= min_d;
            sec_q      <= sec_d;
            rollover_q <= rollover_d;
            if (pause_p) begin
                running_q <= ~running_q;
            end
        end
    end

    assign min_tens = min_q.tens;
    assign min_ones = min_q.ones;
    assign sec_tens = sec_q.tens;
    assign sec_ones = sec_q.ones;
    assign running  = running_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus a random
// soak, all compared against a minutes/seconds integer model.
module tb_stopwatch_counter;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       adj_tick = 1'b0;
    logic       pause_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, rollover;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   m_min = 0;
    int   m_sec = 0;
    logic m_run = 1'b0;
    logic m_roll = 1'b0;
    logic m_tick_d = 1'b0;
    logic m_adj_d = 1'b0;

    stopwatch_counter dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .tick_in  (tick_in),
        .adj_tick (adj_tick),
        .pause_p  (pause_p),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .rollover (rollover)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [17:0] exp_vec();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10), m_run, m_roll};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, running, rollover};
    endfunction

    // One clock: model applies the rules to the inputs sampled at this edge.
    task automatic cycle();
        logic tr, ar;
        int t;
        @(posedge clk_in);
        tr = tick_in & ~m_tick_d;
        ar = adj_tick & ~m_adj_d;
        m_tick_d = tick_in;
        m_adj_d  = adj_tick;
        if (rst) begin
            m_min = 0; m_sec = 0; m_run = 1'b0; m_roll = 1'b0;
        end else begin
            m_roll = 1'b0;
            if (!adj && m_run && tr) begin
                t = m_min * 60 + m_sec + 1;
                if (t == 3600) begin
                    t = 0;
                    m_roll = 1'b1;
                end
                m_min = t / 60;
                m_sec = t % 60;
            end else if (adj && ar) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else     m_min = (m_min + 1) % 60;
            end
            if (pause_p) m_run = ~m_run;
        end
        #1;
    endtask

    task automatic pulse_pause();
        pause_p = 1'b1; cycle();
        pause_p = 1'b0; cycle();
    endtask

    task automatic adj_steps(input int n);
        for (int i = 0; i < n; i++) begin
            adj_tick = 1'b1; cycle();
            adj_tick = 1'b0; cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_in = 1'b1; cycle(); cycle();
        if (dut_vec() !== 18'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", dut_vec(), 18'd0);
        end
        checks++;
        rst = 1'b0; cycle();
        tick_in = 1'b0; cycle();
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_count();
        pulse_pause();
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL count_running got %b exp 1", running);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            tick_in = 1'b1; cycle();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL count_rise%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
            checks++;
            tick_in = 1'b0; cycle();
        end
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0010) begin
            errors++;
            $display("FAIL count_final got %h exp 0010", {min_tens, min_ones, sec_tens, sec_ones});
        end
        checks++;
    endtask

    task automatic test_wrap();
        int rolls = 0;
        adj = 1'b1; sel = 1'b0; adj_steps(59);
        sel = 1'b1; adj_steps(48);
        adj = 1'b0; cycle();
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h5958) begin
            errors++;
            $display("FAIL wrap_preload got %h exp 5958", {min_tens, min_ones, sec_tens, sec_ones});
        end
        checks++;
        for (int i = 0; i < 2; i++) begin
            tick_in = 1'b1; cycle();
            rolls += int'(rollover);
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_tick%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
            checks++;
            tick_in = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cycle();
                rolls += int'(rollover);
            end
        end
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || rolls != 1) begin
            errors++;
            $display("FAIL wrap_rollover got %h rolls %0d exp 0000 rolls 1",
                     {min_tens, min_ones, sec_tens, sec_ones}, rolls);
        end
        checks++;
    endtask

    task automatic test_pause();
        for (int i = 0; i < 5; i++) begin
            tick_in = 1'b1; cycle(); tick_in = 1'b0; cycle();
        end
        pulse_pause();
        for (int i = 0; i < 5; i++) begin
            tick_in = 1'b1; cycle(); tick_in = 1'b0; cycle();
        end
        if (dut_vec() !== {16'h0005, 2'b00}) begin
            errors++;
            $display("FAIL pause_hold got %h exp %h", dut_vec(), {16'h0005, 2'b00});
        end
        checks++;
        pulse_pause();
        tick_in = 1'b1; pause_p = 1'b1; cycle();
        tick_in = 1'b0; pause_p = 1'b0; cycle();
        tick_in = 1'b1; cycle(); tick_in = 1'b0; cycle();
        if (dut_vec() !== {16'h0006, 2'b00} || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pause_same_cycle got %h exp %h", dut_vec(), {16'h0006, 2'b00});
        end
        checks++;
    endtask

    task automatic test_adjust();
        adj = 1'b1; sel = 1'b1; adj_steps(52);
        for (int i = 0; i < 3; i++) begin
            adj_tick = 1'b1; cycle();
            if (dut_vec() !== exp_vec() || rollover !== 1'b0) begin
                errors++;
                $display("FAIL adjust_sec%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
            checks++;
            adj_tick = 1'b0; cycle();
        end
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001) begin
            errors++;
            $display("FAIL adjust_sec_wrap got %h exp 0001", {min_tens, min_ones, sec_tens, sec_ones});
        end
        checks++;
        sel = 1'b0; adj_steps(59);
        adj_tick = 1'b1; cycle(); adj_tick = 1'b0; cycle();
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL adjust_min_wrap got %h exp 0001", {min_tens, min_ones, sec_tens, sec_ones});
        end
        checks++;
    endtask

    task automatic test_adj_ignores_ticks();
        pulse_pause();
        adj = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_in = 1'b1; cycle(); tick_in = 1'b0; cycle();
        end
        if (dut_vec() !== {16'h0001, 2'b10}) begin
            errors++;
            $display("FAIL adj_ignore got %h exp %h", dut_vec(), {16'h0001, 2'b10});
        end
        checks++;
        adj = 1'b0;
        tick_in = 1'b1; cycle(); tick_in = 1'b0; cycle();
        if (dut_vec() !== {16'h0002, 2'b10}) begin
            errors++;
            $display("FAIL adj_resume got %h exp %h", dut_vec(), {16'h0002, 2'b10});
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; cycle(); rst = 1'b0; cycle();
        adj = 1'b1; sel = 1'b0; adj_steps(12);
        sel = 1'b1; adj_steps(34);
        adj = 1'b0; pulse_pause();
        if (dut_vec() !== {16'h1234, 2'b10}) begin
            errors++;
            $display("FAIL reset_mid_setup got %h exp %h", dut_vec(), {16'h1234, 2'b10});
        end
        checks++;
        tick_in = 1'b1; rst = 1'b1; cycle();
        if (dut_vec() !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid got %h exp 0", dut_vec());
        end
        checks++;
        rst = 1'b0; cycle();
        pulse_pause();
        for (int i = 0; i < 3; i++) cycle();
        if (dut_vec() !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL reset_no_spurious got %h exp %h", dut_vec(), {16'h0000, 2'b10});
        end
        checks++;
        tick_in = 1'b0; cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            tick_in  = 1'($urandom_range(0, 1));
            adj_tick = 1'($urandom_range(0, 1));
            pause_p  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) adj = ~adj;
            if ($urandom_range(0, 29) == 0) sel = ~sel;
            rst = ($urandom_range(0, 499) == 0);
            cycle();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_c%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        rst = 1'b0; pause_p = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_adjust();
        test_adj_ignores_ticks();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
